imem_port_arbiter: RTL and testbench

- Shares the single-port byte-addressed memory (combinational read, 32-bit write on clock edge, base-offset addressing) between an instruction-fetch requester and a load/store requester.
- Round-robin arbitration. Sub-word stores are handled by read-modify-write. Load lanes are extracted and zero-extended.
- Out-of-range and misaligned accesses are flagged as errors.
- Sits between the fetch/LSU stages and the memory instance.

---
 rtl/imem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, combinational-read memory
// between an instruction-fetch port and a load/store port.
// Ports:
//   clock, reset          : clock and asynchronous active-low reset
//   if_req/if_addr        : fetch request (word access), held until if_gnt
//   if_gnt/if_rvalid/if_rdata/if_err : fetch grant and one-cycle response
//   d_req/d_addr/d_we/d_size/d_wdata : data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata/d_err     : data grant and one-cycle response
//   mem_address/mem_data_in/mem_read_write/mem_data_out : memory interface
module imem_port_arbiter #(
  parameter logic [31:0] MEM_BASE  = 32'h01000000,
  parameter logic [31:0] MEM_BYTES = 32'h00100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out
);

  localparam logic [32:0] MEM_END = 33'(MEM_BASE) + 33'(MEM_BYTES);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic        last_d_q;          // 1: data port was granted last
  logic [31:0] addr_q, data_q;
  logic [31:0] data_d, addr_c;
  logic        gnt_if_c, gnt_d_c, we_c, rmw_start_c;
  logic        if_legal_c, d_legal_c;
  logic [31:0] merged_c, load_c, wdata_c;
  logic        if_rvalid_q, if_err_q, d_rvalid_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  // Range (33-bit, wrap-safe) and natural-alignment check
  function automatic logic legal_f(input logic [31:0] addr, input logic [1:0] size);
    logic [32:0] last;
    logic        ok;
    case (size)
      2'd0:    last = {1'b0, addr};
      2'd1:    last = {1'b0, addr} + 33'd1;
      default: last = {1'b0, addr} + 33'd3;
    endcase
    ok = (addr >= MEM_BASE) && (last < MEM_END);
    case (size)
      2'd1:    ok = ok && !addr[0];
      2'd2:    ok = ok && (addr[1:0] == 2'b00);
      2'd3:    ok = 1'b0;
      default: ok = ok;
    endcase
    return ok;
  endfunction

  // Lane merge for sub-word stores and lane extraction for loads
  always_comb begin
    merged_c = mem_data_out;
    load_c   = mem_data_out;
    if (d_size == 2'd0) begin
      case (d_addr[1:0])
        2'd0: begin merged_c[7:0]   = d_wdata[7:0]; load_c = {24'b0, mem_data_out[7:0]};   end
        2'd1: begin merged_c[15:8]  = d_wdata[7:0]; load_c = {24'b0, mem_data_out[15:8]};  end
        2'd2: begin merged_c[23:16] = d_wdata[7:0]; load_c = {24'b0, mem_data_out[23:16]}; end
        default: begin merged_c[31:24] = d_wdata[7:0]; load_c = {24'b0, mem_data_out[31:24]}; end
      endcase
    end else if (d_size == 2'd1) begin
      if (d_addr[1]) begin
        merged_c[31:16] = d_wdata[15:0];
        load_c          = {16'b0, mem_data_out[31:16]};
      end else begin
        merged_c[15:0]  = d_wdata[15:0];
        load_c          = {16'b0, mem_data_out[15:0]};
      end
    end
  end

  // Next state, grants and memory drive
  always_comb begin
    state_d     = state_q;
    gnt_if_c    = 1'b0;
    gnt_d_c     = 1'b0;
    we_c        = 1'b0;
    rmw_start_c = 1'b0;
    wdata_c     = data_q;
    data_d      = data_q;
    addr_c      = addr_q;
    if_legal_c  = legal_f(if_addr, 2'd2);
    d_legal_c   = legal_f(d_addr, d_size);

    // reset gating keeps grants low while reset is held
    if (state_q == IDLE && reset) begin
      if (if_req && d_req) begin
        gnt_if_c = last_d_q;
        gnt_d_c  = !last_d_q;
      end else begin
        gnt_if_c = if_req;
        gnt_d_c  = d_req;
      end
    end

    if (gnt_if_c)     addr_c = {if_addr[31:2], 2'b00};
    else if (gnt_d_c) addr_c = {d_addr[31:2], 2'b00};

    if (gnt_d_c && d_legal_c && d_we) begin
      if (d_size == 2'd2) begin
        we_c    = 1'b1;
        wdata_c = d_wdata;
        data_d  = d_wdata;
      end else begin
        rmw_start_c = 1'b1;
        data_d      = merged_c;
        state_d     = RMW_WR;
      end
    end

    if (state_q == RMW_WR) begin
      we_c    = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_c;
      data_q  <= data_d;
      if (gnt_if_c || gnt_d_c) last_d_q <= gnt_d_c;

      if_rvalid_q <= gnt_if_c;
      if (gnt_if_c) begin
        if_err_q   <= !if_legal_c;
        if_rdata_q <= if_legal_c ? mem_data_out : '0;
      end

      // sub-word store acknowledges from RMW_WR instead of the grant cycle
      d_rvalid_q <= (gnt_d_c && !rmw_start_c) || (state_q == RMW_WR);
      if (state_q == RMW_WR) begin
        d_err_q   <= 1'b0;
        d_rdata_q <= '0;
      end else if (gnt_d_c) begin
        d_err_q   <= !d_legal_c;
        d_rdata_q <= (d_legal_c && !d_we) ? load_c : '0;
      end
    end
  end

  assign if_gnt         = gnt_if_c;
  assign d_gnt          = gnt_d_c;
  assign if_rvalid      = if_rvalid_q;
  assign if_err         = if_err_q;
  assign if_rdata       = if_rdata_q;
  assign d_rvalid       = d_rvalid_q;
  assign d_err          = d_err_q;
  assign d_rdata        = d_rdata_q;
  assign mem_address    = addr_c;
  assign mem_data_in    = wdata_c;
  assign mem_read_write = we_c;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small word memory model.
module tb_imem_port_arbiter;

  localparam logic [31:0] MEM_BASE  = 32'h01000000;
  localparam logic [31:0] MEM_BYTES = 32'h00100000;

  logic        clock, reset;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:63];
  logic [5:0]  widx;

  imem_port_arbiter #(.MEM_BASE(MEM_BASE), .MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_size(d_size), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Base-offset memory: combinational read, word write on rising edge
  assign widx         = 6'((mem_address - MEM_BASE) >> 2);
  assign mem_data_out = mem[widx];
  always @(posedge clock) if (mem_read_write) mem[widx] <= mem_data_in;

  task automatic test_reset;
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = MEM_BASE; d_addr = MEM_BASE; d_we = 1'b0; d_size = 2'd2; d_wdata = '0;
    @(negedge clock); #1;
    n_vec++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b%b want 00", if_gnt, d_gnt); end
    n_vec++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_err !== 1'b0 || d_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp: got %b%b%b%b want 0000", if_rvalid, d_rvalid, if_err, d_err); end
    n_vec++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h %h want 0", if_rdata, d_rdata); end
    n_vec++; if (mem_address !== 32'h0 || mem_data_in !== 32'h0 || mem_read_write !== 1'b0) begin n_err++; $display("FAIL reset_mem: got %h %h %b want 0", mem_address, mem_data_in, mem_read_write); end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_fetch;
    @(negedge clock); if_req = 1'b1; if_addr = MEM_BASE + 32'd8; #1;
    n_vec++; if (if_gnt !== 1'b1 || mem_address !== 32'h01000008 || mem_read_write !== 1'b0) begin n_err++; $display("FAIL fetch_gnt: got %b %h %b want 1 01000008 0", if_gnt, mem_address, mem_read_write); end
    @(negedge clock); if_req = 1'b0; #1;
    n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_err !== 1'b0) begin n_err++; $display("FAIL fetch_rsp: got %b %h %b want 1 deadbeef 0", if_rvalid, if_rdata, if_err); end
    @(negedge clock); #1;
    n_vec++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_pulse: got %b want 0", if_rvalid); end
  endtask

  task automatic test_back_to_back_loads;
    @(negedge clock); d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = MEM_BASE + 32'd2; #1;
    n_vec++; if (d_gnt !== 1'b1 || mem_address !== MEM_BASE) begin n_err++; $display("FAIL half_gnt: got %b %h want 1 %h", d_gnt, mem_address, MEM_BASE); end
    @(negedge clock); d_size = 2'd0; d_addr = MEM_BASE + 32'd1; #1;
    n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h00001122 || d_err !== 1'b0) begin n_err++; $display("FAIL half_load: got %b %h %b want 1 00001122 0", d_rvalid, d_rdata, d_err); end
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL byte_gnt: got %b want 1", d_gnt); end
    @(negedge clock); d_req = 1'b0; #1;
    n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h00000033) begin n_err++; $display("FAIL byte_load: got %b %h want 1 00000033", d_rvalid, d_rdata); end
  endtask

  task automatic test_alternate;
    logic exp_if;
    @(negedge clock);
    if_req = 1'b1; if_addr = MEM_BASE + 32'd8;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = MEM_BASE + 32'd4;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_if = (k % 2 == 0);
      n_vec++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin n_err++; $display("FAIL alt_gnt%0d: got %b%b want %b%b", k, if_gnt, d_gnt, exp_if, !exp_if); end
      if (k > 0) begin
        n_vec++; if (if_rvalid !== !exp_if || d_rvalid !== exp_if) begin n_err++; $display("FAIL alt_rsp%0d: got %b%b want %b%b", k, if_rvalid, d_rvalid, !exp_if, exp_if); end
      end
      @(negedge clock);
    end
    if_req = 1'b0; d_req = 1'b0; #1;
    n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11223344 || if_rvalid !== 1'b0) begin n_err++; $display("FAIL alt_last: got %b %h %b want 1 11223344 0", d_rvalid, d_rdata, if_rvalid); end
  endtask

  task automatic test_word_store;
    @(negedge clock); d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = MEM_BASE + 32'd12; d_wdata = 32'hCAFEF00D; #1;
    n_vec++; if (d_gnt !== 1'b1 || mem_read_write !== 1'b1 || mem_data_in !== 32'hCAFEF00D || mem_address !== 32'h0100000C) begin n_err++; $display("FAIL wstore_drv: got %b %b %h %h", d_gnt, mem_read_write, mem_data_in, mem_address); end
    @(negedge clock); d_req = 1'b0; #1;
    n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0 || mem_read_write !== 1'b0) begin n_err++; $display("FAIL wstore_ack: got %b %h %b %b want 1 0 0 0", d_rvalid, d_rdata, d_err, mem_read_write); end
    n_vec++; if (mem[3] !== 32'hCAFEF00D) begin n_err++; $display("FAIL wstore_mem: got %h want cafef00d", mem[3]); end
  endtask

  task automatic test_byte_store;
    @(negedge clock); d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = MEM_BASE + 32'd6; d_wdata = 32'h000000A5; #1;
    n_vec++; if (d_gnt !== 1'b1 || mem_read_write !== 1'b0) begin n_err++; $display("FAIL rmw_rd: got %b %b want 1 0", d_gnt, mem_read_write); end
    @(negedge clock); d_req = 1'b0; if_req = 1'b1; if_addr = MEM_BASE + 32'd8; #1;
    n_vec++; if (mem_read_write !== 1'b1 || mem_data_in !== 32'h11A53344 || mem_address !== 32'h01000004) begin n_err++; $display("FAIL rmw_wr: got %b %h %h want 1 11a53344 01000004", mem_read_write, mem_data_in, mem_address); end
    n_vec++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || d_rvalid !== 1'b0) begin n_err++; $display("FAIL rmw_nogrant: got %b%b%b want 000", if_gnt, d_gnt, d_rvalid); end
    @(negedge clock); #1;
    n_vec++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0 || mem_read_write !== 1'b0) begin n_err++; $display("FAIL rmw_ack: got %b %b %h %b want 1 0 0 0", d_rvalid, d_err, d_rdata, mem_read_write); end
    n_vec++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL rmw_fetch_gnt: got %b want 1", if_gnt); end
    n_vec++; if (mem[1] !== 32'h11A53344) begin n_err++; $display("FAIL rmw_mem: got %h want 11a53344", mem[1]); end
    @(negedge clock); if_req = 1'b0; #1;
    n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rmw_fetch_rsp: got %b %h want 1 deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_errors;
    logic        e_if  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        e_we  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  e_sz  [6] = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2};
    logic [31:0] e_adr [6] = '{MEM_BASE + 32'd2, MEM_BASE - 32'd4, MEM_BASE,
                               MEM_BASE + MEM_BYTES - 32'd4, MEM_BASE + MEM_BYTES, 32'hFFFFFFFC};
    logic        e_err [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (e_if[i]) begin if_req = 1'b1; if_addr = e_adr[i]; end
      else begin d_req = 1'b1; d_we = e_we[i]; d_size = e_sz[i]; d_addr = e_adr[i]; d_wdata = 32'h5A5A5A5A; end
      #1;
      n_vec++; if ((e_if[i] ? if_gnt : d_gnt) !== 1'b1 || mem_read_write !== 1'b0) begin n_err++; $display("FAIL err_gnt%0d: got gnt %b we %b want 1 0", i, e_if[i] ? if_gnt : d_gnt, mem_read_write); end
      @(negedge clock); if_req = 1'b0; d_req = 1'b0; #1;
      n_vec++; if ((e_if[i] ? if_rvalid : d_rvalid) !== 1'b1 || (e_if[i] ? if_err : d_err) !== e_err[i] || mem_read_write !== 1'b0) begin n_err++; $display("FAIL err_rsp%0d: got rvalid %b err %b want 1 %b", i, e_if[i] ? if_rvalid : d_rvalid, e_if[i] ? if_err : d_err, e_err[i]); end
      if (e_err[i]) begin
        n_vec++; if ((e_if[i] ? if_rdata : d_rdata) !== 32'h0) begin n_err++; $display("FAIL err_rdata%0d: got %h want 0", i, e_if[i] ? if_rdata : d_rdata); end
      end
    end
  endtask

  task automatic test_rmw_reset;
    @(negedge clock); d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = MEM_BASE + 32'd4; d_wdata = 32'h00000077; #1;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL rr_gnt: got %b want 1", d_gnt); end
    @(negedge clock); d_req = 1'b0; #1;
    reset = 1'b0; #1;
    n_vec++; if (mem_read_write !== 1'b0 || mem_address !== 32'h0 || mem_data_in !== 32'h0 || d_rvalid !== 1'b0) begin n_err++; $display("FAIL rr_outs: got %b %h %h %b want 0", mem_read_write, mem_address, mem_data_in, d_rvalid); end
    @(negedge clock); reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL rr_norsp%0d: got %b want 0", k, d_rvalid); end
      @(negedge clock);
    end
    n_vec++; if (mem[1] !== 32'h11A53344) begin n_err++; $display("FAIL rr_mem: got %h want 11a53344", mem[1]); end
    if_req = 1'b1; if_addr = MEM_BASE + 32'd8; d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = MEM_BASE; #1;
    n_vec++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_err++; $display("FAIL rr_first: got %b%b want 10", if_gnt, d_gnt); end
    @(negedge clock); if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h11223344;
    mem[2] = 32'hDEADBEEF;
    test_reset();
    test_fetch();
    test_back_to_back_loads();
    test_alternate();
    test_word_store();
    test_byte_store();
    test_errors();
    test_rmw_reset();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
